// File: rtl/seg_scan_controller_if.sv
// Bus between the stopwatch core and the display scan controller:
// digit data/load handshake in one direction, scan drive in the other.
interface seg_scan_controller_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DIG_W      = 5
);
    logic                        enable;
    logic [NUM_DIGITS*DIG_W-1:0] digits_in;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic                        blank_lz;
    logic                        load;
    logic                        load_ack;
    logic [DIG_W-1:0]            dec_v;
    logic [NUM_DIGITS-1:0]       an_n;
    logic                        dp_n;
    logic                        frame_done;

    modport master (
        output enable, digits_in, dp_in, blank_lz, load,
        input  load_ack, dec_v, an_n, dp_n, frame_done
    );

    modport slave (
        input  enable, digits_in, dp_in, blank_lz, load,
        output load_ack, dec_v, an_n, dp_n, frame_done
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Time-multiplexed seven-segment scan sequencer: one digit lit at a time with
// dark gaps between digits, leading-zero blanking, and frame-aligned updates.
module seg_scan_controller #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK_GAP   = 8,
    parameter int DIG_W       = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    seg_scan_controller_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;
    localparam int ON_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int GAP_W = (BLANK_GAP > 1)   ? $clog2(BLANK_GAP)   : 1;
    localparam int DW    = NUM_DIGITS * DIG_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GAP  = 2'd1;
    localparam logic [1:0] S_ON   = 2'd2;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [ON_W-1:0]  ON_LAST    = ON_W'(REFRESH_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'((BLANK_GAP > 0) ? BLANK_GAP - 1 : 0);
    localparam logic [1:0]       S_PRE_DIG  = (BLANK_GAP > 0) ? S_GAP : S_ON;

    logic [1:0]            state, state_nx;
    logic [IDX_W-1:0]      idx, idx_nx;
    logic [ON_W-1:0]       on_cnt, on_nx;
    logic [GAP_W-1:0]      gap_cnt, gap_nx;
    logic                  boundary;
    logic                  apply;

    logic [DW-1:0]         act_d, act_d_nx, sh_d, sh_d_eff;
    logic [NUM_DIGITS-1:0] act_dp, act_dp_nx, sh_dp, sh_dp_eff;
    logic                  pending;

    logic [DIG_W-1:0]      shown [NUM_DIGITS];
    logic [DIG_W-1:0]      dec_nx;
    logic [NUM_DIGITS-1:0] an_nx;
    logic                  dp_nx;

    // Scan sequencing: gap/on phase counting, digit advance, frame boundary.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        on_nx    = on_cnt;
        gap_nx   = gap_cnt;
        boundary = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.enable) begin
                    state_nx = S_PRE_DIG;
                    idx_nx   = '0;
                    on_nx    = '0;
                    gap_nx   = '0;
                end
            end
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nx = S_ON;
                    gap_nx   = '0;
                end else begin
                    gap_nx = gap_cnt + GAP_W'(1);
                end
            end
            S_ON: begin
                if (on_cnt == ON_LAST) begin
                    on_nx    = '0;
                    state_nx = S_PRE_DIG;
                    if (idx == IDX_LAST) begin
                        idx_nx   = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nx = idx + IDX_W'(1);
                    end
                end else begin
                    on_nx = on_cnt + ON_W'(1);
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // Disable wins over everything, including a frame boundary in the same cycle.
        if (state != S_IDLE && !bus.enable) begin
            state_nx = S_IDLE;
            idx_nx   = '0;
            on_nx    = '0;
            gap_nx   = '0;
            boundary = 1'b0;
        end
    end

    // Load application: a load on the boundary cycle itself bypasses the shadow.
    always_comb begin
        sh_d_eff  = bus.load ? bus.digits_in : sh_d;
        sh_dp_eff = bus.load ? bus.dp_in : sh_dp;
        if (boundary) begin
            apply = pending | bus.load;
        end else begin
            apply = (state == S_IDLE) && pending;
        end
        act_d_nx  = apply ? sh_d_eff : act_d;
        act_dp_nx = apply ? sh_dp_eff : act_dp;
    end

    // Leading-zero blanking, scanning from the most significant digit down.
    always_comb begin
        logic             zero_run;
        logic [DIG_W-1:0] code;
        zero_run = 1'b1;
        code     = '0;
        for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
            code     = act_d_nx[(i-1)*DIG_W +: DIG_W];
            zero_run = zero_run & (code == '0);
            if (bus.blank_lz && zero_run && (i > 1)) begin
                shown[i-1] = '1;
            end else begin
                shown[i-1] = code;
            end
        end
    end

    // Output decode from the next state so registered outputs line up with state.
    always_comb begin
        an_nx  = '1;
        dp_nx  = 1'b1;
        dec_nx = '1;
        case (state_nx)
            S_GAP: dec_nx = shown[idx_nx];
            S_ON: begin
                dec_nx        = shown[idx_nx];
                an_nx[idx_nx] = 1'b0;
                dp_nx         = ~act_dp_nx[idx_nx];
            end
            default: ;
        endcase
    end

    // Scan state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            on_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nx;
            idx     <= idx_nx;
            on_cnt  <= on_nx;
            gap_cnt <= gap_nx;
        end
    end

    // Shadow/active digit data and the pending-load flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_d   <= '1;
            act_dp  <= '0;
            sh_d    <= '0;
            sh_dp   <= '0;
            pending <= 1'b0;
        end else begin
            act_d  <= act_d_nx;
            act_dp <= act_dp_nx;
            if (bus.load) begin
                sh_d  <= bus.digits_in;
                sh_dp <= bus.dp_in;
            end
            if (apply) begin
                pending <= 1'b0;
            end else if (bus.load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered display drive and event pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an_n       <= '1;
            bus.dp_n       <= 1'b1;
            bus.dec_v      <= '1;
            bus.frame_done <= 1'b0;
            bus.load_ack   <= 1'b0;
        end else begin
            bus.an_n       <= an_nx;
            bus.dp_n       <= dp_nx;
            bus.dec_v      <= dec_nx;
            bus.frame_done <= boundary;
            bus.load_ack   <= apply;
        end
    end
endmodule
